// File: rtl/lo_seq_pkg.sv
// Shared types and helpers for the local oscillator table sequencer.
package lo_seq_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;

  // RAM read register plus output register
  localparam int PIPE_LATENCY = 2;

  // A length of 0 or anything beyond the table depth means "use the whole table"
  function automatic logic [31:0] eff_len(input logic [31:0] tl, input int unsigned aw);
    logic [31:0] full;
    full = 32'd1 << aw;
    if (tl == 32'd0 || tl > full) return full;
    return tl;
  endfunction

endpackage

// File: rtl/lo_seq_addr_gen.sv
// Read address generator: table counter, wrap at latched length, sync alignment
// check and pass counter. Optional phase offset under LO_SEQ_PHASE_OFFSET_EN.
module lo_seq_addr_gen
  import lo_seq_pkg::*;
#(
  parameter int ADDR_WIDTH       = 10,
  parameter int PASS_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  state_t                      state,
  input  logic                        enable,
  input  logic                        sync,
  input  logic [ADDR_WIDTH:0]         tableLength,
`ifdef LO_SEQ_PHASE_OFFSET_EN
  input  logic [ADDR_WIDTH-1:0]       phaseOffset,
`endif
  output logic [ADDR_WIDTH-1:0]       rAddr,
  output logic                        issue,
  output logic                        first,
  output logic                        align_err,
  output logic [PASS_COUNT_WIDTH-1:0] passCount
);

  localparam int LW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d, addr_d;
  logic [ADDR_WIDTH:0]         len_q, len_d, len_in, len_m1;
  logic [PASS_COUNT_WIDTH-1:0] pc_d;
  logic                        last, relatch;

`ifdef LO_SEQ_PHASE_OFFSET_EN
  logic [ADDR_WIDTH-1:0] off_q, off_d, off_in;
  logic [ADDR_WIDTH:0]   sum_w;
  assign off_in = ({1'b0, phaseOffset} >= len_in) ? '0 : phaseOffset;
`endif

  assign len_in = LW'(eff_len(32'(tableLength), ADDR_WIDTH));
  assign len_m1 = len_q - 1'b1;
  assign last   = ({1'b0, cnt_q} == len_m1);
  // rAddr is a real read in RUN, and in the WAIT_SYNC cycle that sees sync
  assign issue  = (state == RUN) || (state == WAIT_SYNC && enable && sync);
  assign first  = (cnt_q == '0);

  // Next counter / pass count; length (and offset) only reload at pass boundaries
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    pc_d      = passCount;
    align_err = 1'b0;
    relatch   = 1'b0;
`ifdef LO_SEQ_PHASE_OFFSET_EN
    off_d     = off_q;
    sum_w     = '0;
`endif
    case (state)
      RUN: begin
        if (enable && sync && !last) begin
          // misaligned sync: restart the table as a fresh pass
          align_err = 1'b1;
          cnt_d     = '0;
          relatch   = 1'b1;
        end else if (last) begin
          cnt_d   = '0;
          pc_d    = passCount + 1'b1;
          relatch = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_SYNC: begin
        if (enable && sync) begin
          // counter 0 is being read this cycle
          pc_d = '0;
          if (last) begin
            cnt_d   = '0;
            pc_d    = PASS_COUNT_WIDTH'(1);
            relatch = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          relatch = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        relatch = 1'b1;
      end
    endcase
    if (relatch) len_d = len_in;
    if (!enable) cnt_d = '0;
`ifdef LO_SEQ_PHASE_OFFSET_EN
    if (relatch) off_d = off_in;
    // (counter + offset) mod L with a single conditional subtract
    sum_w = {1'b0, cnt_d} + {1'b0, off_d};
    if (sum_w >= len_d) sum_w = sum_w - len_d;
    addr_d = sum_w[ADDR_WIDTH-1:0];
`else
    addr_d = cnt_d;
`endif
    if (!enable) addr_d = '0;
  end

  // Counter, latched length/offset, registered read address and pass count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_q     <= {1'b1, {ADDR_WIDTH{1'b0}}};
      rAddr     <= '0;
      passCount <= '0;
`ifdef LO_SEQ_PHASE_OFFSET_EN
      off_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rAddr     <= addr_d;
      passCount <= pc_d;
`ifdef LO_SEQ_PHASE_OFFSET_EN
      off_q     <= off_d;
`endif
    end
  end

endmodule

// File: rtl/local_oscillator_sequencer.sv
// LO table read sequencer: FSM, output sample pipeline, sync error flag.
// Optional phase offset input enabled by LO_SEQ_PHASE_OFFSET_EN.
module local_oscillator_sequencer
  import lo_seq_pkg::*;
#(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 18,
  parameter int PASS_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sync,
  input  logic [ADDR_WIDTH:0]         tableLength,
  input  logic                        errorClear,
`ifdef LO_SEQ_PHASE_OFFSET_EN
  input  logic [ADDR_WIDTH-1:0]       phaseOffset,
`endif
  output logic [ADDR_WIDTH-1:0]       rAddr,
  input  logic [2*DATA_WIDTH-1:0]     rData,
  output logic [DATA_WIDTH-1:0]       loCos,
  output logic [DATA_WIDTH-1:0]       loSin,
  output logic                        loValid,
  output logic                        loFirst,
  output logic [PASS_COUNT_WIDTH-1:0] passCount,
  output logic                        syncError,
  output logic                        running
);

  state_t                  state, state_d;
  logic                    issue, first, align_err;
  logic [PIPE_LATENCY:1]   vld_pipe, fst_pipe;

  lo_seq_addr_gen #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .PASS_COUNT_WIDTH (PASS_COUNT_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .enable      (enable),
    .sync        (sync),
    .tableLength (tableLength),
`ifdef LO_SEQ_PHASE_OFFSET_EN
    .phaseOffset (phaseOffset),
`endif
    .rAddr       (rAddr),
    .issue       (issue),
    .first       (first),
    .align_err   (align_err),
    .passCount   (passCount)
  );

  // Next-state: enable low always wins and returns to IDLE
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = WAIT_SYNC;
      WAIT_SYNC: if (sync) state_d = RUN;
      RUN:       state_d = RUN;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // State register, running flag and sticky sync error (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      running   <= 1'b0;
      syncError <= 1'b0;
    end else begin
      state   <= state_d;
      running <= (state_d == RUN);
      if (align_err)       syncError <= 1'b1;
      else if (errorClear) syncError <= 1'b0;
    end
  end

  // Valid/first delay lines track reads through the RAM; only rst flushes them
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
      loCos    <= '0;
      loSin    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LATENCY-1:1], issue};
      fst_pipe <= {fst_pipe[PIPE_LATENCY-1:1], issue & first};
      if (vld_pipe[PIPE_LATENCY-1]) begin
        loCos <= rData[DATA_WIDTH-1:0];
        loSin <= rData[2*DATA_WIDTH-1:DATA_WIDTH];
      end
    end
  end

  assign loValid = vld_pipe[PIPE_LATENCY];
  assign loFirst = fst_pipe[PIPE_LATENCY];

endmodule

// File: tb/tb_local_oscillator_sequencer.sv
// Bench for local_oscillator_sequencer: directed table, corner sequences and
// randomized traffic against a pass/position reference model.
module tb_local_oscillator_sequencer;
  localparam int AW = 4, DW = 18, PCW = 16, N = 1 << AW;

  logic           clk = 1'b0;
  logic           rst, enable, sync, errorClear;
  logic [AW:0]    tableLength;
  logic [AW-1:0]  rAddr;
  logic [2*DW-1:0] rData;
  logic [DW-1:0]  loCos, loSin;
  logic           loValid, loFirst, syncError, running;
  logic [PCW-1:0] passCount;
`ifdef LO_SEQ_PHASE_OFFSET_EN
  logic [AW-1:0]  phaseOffset;
`endif

  int checks = 0, passed = 0;
  logic [2*DW-1:0] ram [N];

  always #5 clk = ~clk;
  always @(posedge clk) rData <= ram[rAddr];

  local_oscillator_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PASS_COUNT_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync), .tableLength(tableLength),
    .errorClear(errorClear),
`ifdef LO_SEQ_PHASE_OFFSET_EN
    .phaseOffset(phaseOffset),
`endif
    .rAddr(rAddr), .rData(rData), .loCos(loCos), .loSin(loSin), .loValid(loValid),
    .loFirst(loFirst), .passCount(passCount), .syncError(syncError), .running(running));

  // ---------------- reference model ----------------
  typedef struct { bit v; int a; bit f; } rd_t;
  rd_t pend[$];          // reads in flight, oldest first
  int  m_mode;           // 0 idle, 1 armed, 2 running
  int  m_pos, m_L, m_off, m_raddr;
  logic [PCW-1:0] m_pass;
  bit  m_err, m_run, m_v, m_f;
  logic [DW-1:0] m_cos, m_sin;

  function automatic int lin();
    return (tableLength == 0 || int'(tableLength) > N) ? N : int'(tableLength);
  endfunction

  function automatic int off_in();
`ifdef LO_SEQ_PHASE_OFFSET_EN
    return (int'(phaseOffset) >= lin()) ? 0 : int'(phaseOffset);
`else
    return 0;
`endif
  endfunction

  task automatic advance(input int li, input int oi);
    m_pos++;
    if (m_pos >= m_L) begin
      m_pos = 0; m_pass++; m_L = li; m_off = oi;
    end
  endtask

  task automatic model_edge();
    rd_t cur, e;
    int li, oi;
    bit new_err;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_L = N; m_off = 0; m_pass = '0; m_err = 0; m_run = 0;
      m_v = 0; m_f = 0; m_cos = '0; m_sin = '0; m_raddr = 0;
      pend.delete(); pend.push_back('{0, 0, 0});
      return;
    end
    li = lin(); oi = off_in();
    cur.v = (m_mode == 2) || (m_mode == 1 && enable && sync);
    cur.a = m_raddr; cur.f = (m_pos == 0);
    e = pend.pop_front(); pend.push_back(cur);
    m_v = e.v; m_f = e.v && e.f;
    if (e.v) begin m_cos = ram[e.a][DW-1:0]; m_sin = ram[e.a][2*DW-1:DW]; end
    new_err = 0;
    case (m_mode)
      0: begin m_pos = 0; m_L = li; m_off = oi; if (enable) m_mode = 1; end
      1: if (enable && sync) begin m_mode = 2; m_pass = '0; advance(li, oi); end
         else begin m_pos = 0; m_L = li; m_off = oi; end
      default:
        if (enable && sync && m_pos != m_L - 1) begin
          new_err = 1; m_pos = 0; m_L = li; m_off = oi;
        end else advance(li, oi);
    endcase
    if (new_err) m_err = 1; else if (errorClear) m_err = 0;
    if (!enable) begin m_mode = 0; m_pos = 0; end
    m_raddr = (m_mode == 0) ? 0 : (m_pos + m_off) % m_L;
    m_run = (m_mode == 2);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    chk("rAddr", 64'(rAddr), 64'(m_raddr));
    chk("loValid", 64'(loValid), 64'(m_v));
    chk("loFirst", 64'(loFirst), 64'(m_f));
    chk("loCos", 64'(loCos), 64'(m_cos));
    chk("loSin", 64'(loSin), 64'(m_sin));
    chk("passCount", 64'(passCount), 64'(m_pass));
    chk("syncError", 64'(syncError), 64'(m_err));
    chk("running", 64'(running), 64'(m_run));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  // step until the model shows the wanted address (and pass, if p >= 0)
  task automatic wait_addr(input int a, input int p);
    int n = 0;
    while (!(m_raddr == a && (p < 0 || int'(m_pass) == p)) && n < 200) begin
      step(); n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL wait_addr: address %0d pass %0d not reached in 200 cycles", a, p);
    end
  endtask

  task automatic rearm(input int tl);
    enable = 0; step();
    tableLength = (AW+1)'(tl);
    enable = 1; step(); step();
    sync = 1; step(); sync = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit en, sy; int tl;
    int e_addr; bit e_v, e_f, e_run; int e_lo, e_pass;
  } vec_t;
  vec_t tv[13];

  initial begin
    int v_seen[3];
    for (int i = 0; i < N; i++) ram[i] = {$urandom(), $urandom()};
    // en sy tl | rAddr valid first running loAddr passCount
    tv[0]  = '{0, 0, 8, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 8, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 0, 8, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 1, 8, 1, 0, 0, 1, 0, 0};
    tv[4]  = '{1, 0, 8, 2, 1, 1, 1, 0, 0};
    tv[5]  = '{1, 0, 8, 3, 1, 0, 1, 1, 0};
    tv[6]  = '{1, 0, 8, 4, 1, 0, 1, 2, 0};
    tv[7]  = '{1, 0, 8, 5, 1, 0, 1, 3, 0};
    tv[8]  = '{1, 0, 8, 6, 1, 0, 1, 4, 0};
    tv[9]  = '{1, 0, 8, 7, 1, 0, 1, 5, 0};
    tv[10] = '{1, 0, 8, 0, 1, 0, 1, 6, 1};
    tv[11] = '{1, 0, 8, 1, 1, 0, 1, 7, 1};
    tv[12] = '{1, 0, 8, 2, 1, 1, 1, 0, 1};

    rst = 1; enable = 0; sync = 0; errorClear = 0; tableLength = 5'd8;
`ifdef LO_SEQ_PHASE_OFFSET_EN
    phaseOffset = '0;
`endif
    step(); step();
    chk("rst_rAddr", 64'(rAddr), 64'd0);
    chk("rst_loValid", 64'(loValid), 64'd0);
    chk("rst_passCount", 64'(passCount), 64'd0);
    chk("rst_syncError", 64'(syncError), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_loCos", 64'(loCos), 64'd0);
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      enable = tv[i].en; sync = tv[i].sy; tableLength = (AW+1)'(tv[i].tl);
      step();
      chk($sformatf("tv%0d_rAddr", i), 64'(rAddr), 64'(tv[i].e_addr));
      chk($sformatf("tv%0d_loValid", i), 64'(loValid), 64'(tv[i].e_v));
      chk($sformatf("tv%0d_loFirst", i), 64'(loFirst), 64'(tv[i].e_f));
      chk($sformatf("tv%0d_running", i), 64'(running), 64'(tv[i].e_run));
      chk($sformatf("tv%0d_passCount", i), 64'(passCount), 64'(tv[i].e_pass));
      if (tv[i].e_v) chk($sformatf("tv%0d_loCos", i), 64'(loCos), 64'(ram[tv[i].e_lo][DW-1:0]));
    end
    sync = 0;

    // aligned sync while issuing the last entry of pass 3
    wait_addr(7, 3);
    chk("align_pass_before", 64'(passCount), 64'd3);
    sync = 1; step(); sync = 0;
    chk("align_syncError", 64'(syncError), 64'd0);
    chk("align_pass_after", 64'(passCount), 64'd4);
    chk("align_rAddr", 64'(rAddr), 64'd0);

    // misaligned sync mid-pass: realign, flag, clear, set beats clear
    wait_addr(3, -1);
    sync = 1; step(); sync = 0;
    chk("misalign_syncError", 64'(syncError), 64'd1);
    chk("misalign_rAddr", 64'(rAddr), 64'd0);
    chk("misalign_pass", 64'(passCount), 64'd4);
    errorClear = 1; step(); errorClear = 0;
    chk("clear_syncError", 64'(syncError), 64'd0);
    sync = 1; errorClear = 1; step(); sync = 0; errorClear = 0;
    chk("set_wins_syncError", 64'(syncError), 64'd1);
    errorClear = 1; step(); errorClear = 0;

    // tableLength 0 -> full 16-entry table
    rearm(0);
    chk("len0_start", 64'(rAddr), 64'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("len0_rAddr%0d", i), 64'(rAddr), 64'((i + 2) % 16));
    end

    // tableLength 1 -> address 0 forever, every sample is first
    rearm(1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("len1_rAddr", 64'(rAddr), 64'd0);
      chk("len1_first", 64'(loFirst), 64'(loValid));
      if (i >= 1) chk("len1_valid", 64'(loValid), 64'd1);
    end

    // enable drop mid-pass: exactly two trailing valids
    rearm(8);
    wait_addr(5, -1);
    enable = 0;
    for (int i = 0; i < 3; i++) begin step(); v_seen[i] = int'(loValid); end
    chk("drop_v1", 64'(v_seen[0]), 64'd1);
    chk("drop_v2", 64'(v_seen[1]), 64'd1);
    chk("drop_v3", 64'(v_seen[2]), 64'd0);
    chk("drop_rAddr", 64'(rAddr), 64'd0);
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rearm_running", 64'(running), 64'd0);
      chk("rearm_valid", 64'(loValid), 64'd0);
    end

`ifdef LO_SEQ_PHASE_OFFSET_EN
    // phase offset 6 on an 8-entry table
    enable = 0; step();
    tableLength = 5'd8; phaseOffset = 4'd6; enable = 1; step();
    chk("off_wait_rAddr", 64'(rAddr), 64'd6);
    sync = 1; step(); sync = 0;
    chk("off_rAddr7", 64'(rAddr), 64'd7);
    step();
    chk("off_rAddr0", 64'(rAddr), 64'd0);
    chk("off_first", 64'(loFirst), 64'd1);
    chk("off_cos", 64'(loCos), 64'(ram[6][DW-1:0]));
    step();
    chk("off_rAddr1", 64'(rAddr), 64'd1);
    // offset beyond the table is ignored
    enable = 0; step();
    phaseOffset = 4'd9; enable = 1; step();
    chk("off9_wait_rAddr", 64'(rAddr), 64'd0);
    sync = 1; step(); sync = 0;
    chk("off9_rAddr", 64'(rAddr), 64'd1);
    phaseOffset = '0;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom % 64) != 0;
      sync       = ($urandom % 12) == 0;
      errorClear = ($urandom % 16) == 0;
      if ($urandom % 200 == 0) tableLength = (AW+1)'($urandom_range(0, N + 4));
`ifdef LO_SEQ_PHASE_OFFSET_EN
      if ($urandom % 200 == 0) phaseOffset = AW'($urandom);
`endif
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
